ddr3_dm_delay_line_ctrl: RTL and testbench

Sequencer for the delay-line control pins of one DDR3 PHY lane IOD (DM or DQ bit). Training and calibration logic issues single load/increment/decrement requests; the block turns each request into correctly spaced DELAY_LINE_LOAD / DELAY_LINE_MOVE pulses with a stable DELAY_LINE_DIRECTION. It also tracks the current tap count and stops at tap limits or when the IOD reports out-of-range. It sits in the fabric clock domain between the training FSM and the lane IOD.

---
 rtl/ddr3_dm_delay_line_ctrl.sv | 155 +++++++++++++++
 tb/tb_ddr3_dm_delay_line_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dm_delay_line_ctrl.sv
// Delay-line sequencer for one DDR3 PHY lane IOD (DM/DQ bit).
// Turns load/inc/dec requests into spaced LOAD/MOVE pulses and tracks the tap.
module ddr3_dm_delay_line_ctrl #(
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned MAX_TAP    = 127,
  parameter int unsigned RESET_TAP  = 1,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic              FAB_CLK,
  input  logic              ARST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [STEP_W-1:0] REQ_STEPS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [TAP_W-1:0]  TAP_COUNT,
  output logic              DELAY_LINE_LOAD_0,
  output logic              DELAY_LINE_MOVE_0,
  output logic              DELAY_LINE_DIRECTION_0,
  input  logic              DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_FIN
  } state_t;

  state_t            state;
  logic [STEP_W-1:0] remaining;
  logic [GW-1:0]     gap_cnt;
  logic [TAP_W-1:0]  tap;
  logic              dir_q;
  logic              load_q;
  logic              move_q;
  logic              done_q;
  logic              err_q;
  logic              oor_q;
  logic              limit_hit;

  always_comb begin
    limit_hit = dir_q ? (tap == TAP_W'(MAX_TAP)) : (tap == '0);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
      tap       <= TAP_W'(RESET_TAP);
      dir_q     <= 1'b0;
      load_q    <= 1'b0;
      move_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      load_q <= 1'b0;
      move_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      oor_q  <= DELAY_LINE_OUT_OF_RANGE_0;
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            remaining <= '0;
            case (REQ_OP)
              2'b00: begin
                state  <= S_LOAD;
                load_q <= 1'b1;
              end
              2'b01, 2'b10: begin
                remaining <= REQ_STEPS;
                if (REQ_STEPS == '0) begin
                  state  <= S_FIN;
                  done_q <= 1'b1;
                end else begin
                  state <= S_SETUP;
                  dir_q <= (REQ_OP == 2'b01);
                end
              end
              default: begin
                state  <= S_FIN;
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: begin
          tap     <= TAP_W'(RESET_TAP);
          state   <= S_GAP;
          gap_cnt <= GW'(GAP_CYCLES - 1);
        end
        S_SETUP: begin
          if (limit_hit) begin
            state  <= S_FIN;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state  <= S_MOVE;
            move_q <= 1'b1;
          end
        end
        S_MOVE: begin
          tap       <= dir_q ? tap + 1'b1 : tap - 1'b1;
          remaining <= remaining - 1'b1;
          state     <= S_GAP;
          gap_cnt   <= GW'(GAP_CYCLES - 1);
        end
        S_GAP: begin
          // Last gap cycle: out-of-range abort wins over the boundary check.
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (oor_q) begin
            state  <= S_FIN;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (remaining != '0) begin
            if (limit_hit) begin
              state  <= S_FIN;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state  <= S_MOVE;
              move_q <= 1'b1;
            end
          end else begin
            state  <= S_FIN;
            done_q <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign REQ_READY              = (state == S_IDLE);
  assign BUSY                   = (state != S_IDLE);
  assign DONE                   = done_q;
  assign ERR                    = err_q;
  assign TAP_COUNT              = tap;
  assign DELAY_LINE_LOAD_0      = load_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule

// File: tb/tb_ddr3_dm_delay_line_ctrl.sv
// Directed self-checking bench for ddr3_dm_delay_line_ctrl.
module tb_ddr3_dm_delay_line_ctrl;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_steps = '0;
  logic       busy, done, err;
  logic [7:0] tap_count;
  logic       dl_load, dl_move, dl_dir;
  logic       dl_oor = 1'b0;

  int checks = 0;
  int failures = 0;

  int   mv_q[$];
  int   ld_q[$];
  int   done_cyc;
  logic err_at_done;
  int   viol;

  always #5 clk = ~clk;

  ddr3_dm_delay_line_ctrl #(
    .TAP_W(8), .MAX_TAP(127), .RESET_TAP(1), .STEP_W(8), .GAP_CYCLES(GAP)
  ) dut (
    .FAB_CLK(clk),
    .ARST_N(rst_n),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_OP(req_op),
    .REQ_STEPS(req_steps),
    .BUSY(busy),
    .DONE(done),
    .ERR(err),
    .TAP_COUNT(tap_count),
    .DELAY_LINE_LOAD_0(dl_load),
    .DELAY_LINE_MOVE_0(dl_move),
    .DELAY_LINE_DIRECTION_0(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE_0(dl_oor)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge where READY is high; returns just after the accept edge (cycle 1).
  task automatic accept(input logic [1:0] op, input logic [7:0] steps);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_steps = steps;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Observes cycles 1.. until DONE, recording pulse cycles and protocol violations.
  task automatic run(input logic [1:0] op, input logic [7:0] steps, input int oor_after, input int budget);
    int   last_pulse;
    logic dir0;
    mv_q.delete();
    ld_q.delete();
    done_cyc   = -1;
    err_at_done = 1'bx;
    viol       = 0;
    last_pulse = -100;
    accept(op, steps);
    dir0 = dl_dir;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (!busy || req_ready) viol++;
      if (dl_dir !== dir0) viol++;
      if (dl_load && dl_move) viol++;
      if (dl_load || dl_move) begin
        if (c - last_pulse < GAP + 1) viol++;
        last_pulse = c;
      end
      if (dl_move) begin
        mv_q.push_back(c);
        if (mv_q.size() == oor_after) dl_oor = 1'b1;
      end
      if (dl_load) ld_q.push_back(c);
      if (done) begin
        done_cyc    = c;
        err_at_done = err;
        break;
      end
    end
    check("protocol_violations", 32'(viol), 32'd0);
  endtask

  task automatic check_moves(input string tag, input int n);
    check({tag, "_move_count"}, 32'(mv_q.size()), 32'(n));
    for (int k = 0; k < n && k < mv_q.size(); k++)
      check({tag, "_move_cycle"}, 32'(mv_q[k]), 32'(2 + k * (1 + GAP)));
  endtask

  initial begin
    int dn;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_tap",   32'(tap_count), 32'd1);
    check("rst_pulses", {29'd0, dl_load, dl_move, dl_dir}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // inc 3 from 1
    run(2'b01, 8'd3, -1, 40);
    check_moves("inc3", 3);
    check("inc3_dir", 32'(dl_dir), 32'd1);
    check("inc3_done", 32'(done_cyc), 32'd14);
    check("inc3_err", 32'(err_at_done), 32'd0);
    check("inc3_tap", 32'(tap_count), 32'd4);
    @(posedge clk);
    #1;
    check("inc3_ready_after_done", 32'(req_ready), 32'd1);
    check("inc3_done_one_cycle", 32'(done), 32'd0);

    // load 4 -> 1, then dec 5 from 1
    run(2'b00, 8'd9, -1, 20);
    check("load1_cycle", 32'(ld_q.size() == 1 ? ld_q[0] : -1), 32'd1);
    check("load1_done", 32'(done_cyc), 32'd5);
    check("load1_tap", 32'(tap_count), 32'd1);
    check("load1_moves", 32'(mv_q.size()), 32'd0);

    run(2'b10, 8'd5, -1, 40);
    check_moves("dec5", 1);
    check("dec5_dir", 32'(dl_dir), 32'd0);
    check("dec5_tap", 32'(tap_count), 32'd0);
    check("dec5_done", 32'(done_cyc), 32'd6);
    check("dec5_err", 32'(err_at_done), 32'd1);

    // inc 126 -> 126, then inc 2 hits MAX_TAP
    run(2'b01, 8'd126, -1, 600);
    check("inc126_done", 32'(done_cyc), 32'd506);
    check("inc126_tap", 32'(tap_count), 32'd126);
    run(2'b01, 8'd2, -1, 40);
    check_moves("incmax", 1);
    check("incmax_tap", 32'(tap_count), 32'd127);
    check("incmax_done", 32'(done_cyc), 32'd6);
    check("incmax_err", 32'(err_at_done), 32'd1);

    // dec 87 -> 40, then load
    run(2'b10, 8'd87, -1, 400);
    check("dec87_tap", 32'(tap_count), 32'd40);
    check("dec87_err", 32'(err_at_done), 32'd0);
    run(2'b00, 8'd0, -1, 20);
    check("load40_cycle", 32'(ld_q.size() == 1 ? ld_q[0] : -1), 32'd1);
    check("load40_done", 32'(done_cyc), 32'd5);
    check("load40_err", 32'(err_at_done), 32'd0);
    check("load40_tap", 32'(tap_count), 32'd1);

    // inc 0 and reserved op
    run(2'b01, 8'd0, -1, 10);
    check("inc0_done", 32'(done_cyc), 32'd1);
    check("inc0_err", 32'(err_at_done), 32'd0);
    check("inc0_pulses", 32'(mv_q.size() + ld_q.size()), 32'd0);
    check("inc0_tap", 32'(tap_count), 32'd1);
    run(2'b11, 8'd4, -1, 10);
    check("rsvd_done", 32'(done_cyc), 32'd1);
    check("rsvd_err", 32'(err_at_done), 32'd1);
    check("rsvd_pulses", 32'(mv_q.size() + ld_q.size()), 32'd0);

    // inc 10 with out-of-range raised after the second MOVE
    run(2'b01, 8'd10, 2, 60);
    check_moves("oor", 2);
    check("oor_tap", 32'(tap_count), 32'd3);
    check("oor_done", 32'(done_cyc), 32'd10);
    check("oor_err", 32'(err_at_done), 32'd1);
    dl_oor = 1'b0;
    repeat (3) @(posedge clk);

    // inc 10 with async reset at cycle 7
    accept(2'b01, 8'd10);
    for (int c = 2; c <= 7; c++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_tap", 32'(tap_count), 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tap", 32'(tap_count), 32'd1);
    check("arst_pulses", {29'd0, dl_load, dl_move, dl_dir}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("arst_no_done", 32'(dn), 32'd0);

    run(2'b01, 8'd1, -1, 20);
    check_moves("post_rst", 1);
    check("post_rst_done", 32'(done_cyc), 32'd6);
    check("post_rst_err", 32'(err_at_done), 32'd0);
    check("post_rst_tap", 32'(tap_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
